// File: rtl/sra_0_pkg.sv
// Shared decode constants, ALU-control encoding and the boot program for the sra_0 core.
package sra_0_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } alu_ctrl_e;

    // Boot program: $2 = -2; $4 = $2 >>> 2; mem[8] = $4. Everything else is a no-op.
    function automatic logic [31:0] boot_rom(input int unsigned idx);
        logic [31:0] word;
        case (idx)
            0:       word = 32'h2002FFFE;
            1:       word = 32'h00022083;
            2:       word = 32'hAC040008;
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/sra_0_alu.sv
// Combinational ALU: arithmetic/logic ops plus sll/srl/sra on b by shamt.
module sra_0_alu
    import sra_0_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_ctrl_e   control,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (control)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_SRA: result = $signed(b) >>> shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/sra_0.sv
// Single-cycle MIPS32-subset core with inline controller, register file, ROM and data RAM.
module sra_0
    import sra_0_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] writedata,
    output logic [31:0] dataadr,
    output logic        memwrite
);

    localparam int unsigned IAW = $clog2(IMEM_WORDS);
    localparam int unsigned DAW = $clog2(DMEM_WORDS);

    logic [31:0]    r_pc;
    logic [31:0]    r_rf [32];
    logic [31:0]    r_dmem [DMEM_WORDS];

    logic [31:0]    w_instr;
    logic [5:0]     w_op;
    logic [5:0]     w_fn;
    logic [4:0]     w_rs;
    logic [4:0]     w_rt;
    logic [4:0]     w_rd;
    logic [31:0]    w_simm;
    logic [31:0]    w_rs_val;
    logic [31:0]    w_rt_val;
    logic [31:0]    w_alu_b;
    logic [31:0]    w_alu_res;
    logic           w_zero;
    logic [31:0]    w_rdata;
    logic [31:0]    w_wdata;
    logic [4:0]     w_waddr;
    logic [31:0]    w_pc4;
    logic [31:0]    w_pc_next;
    logic           w_regwrite;
    logic           w_regdst;
    logic           w_alusrc;
    logic           w_memtoreg;
    logic           w_branch;
    logic           w_jump;
    alu_ctrl_e      w_alu_ctrl;

    assign w_instr = boot_rom(int'(r_pc[IAW+1:2]));
    assign w_op    = w_instr[31:26];
    assign w_rs    = w_instr[25:21];
    assign w_rt    = w_instr[20:16];
    assign w_rd    = w_instr[15:11];
    assign w_fn    = w_instr[5:0];
    assign w_simm  = {{16{w_instr[15]}}, w_instr[15:0]};

    always_comb begin
        w_regwrite = 1'b0;
        w_regdst   = 1'b0;
        w_alusrc   = 1'b0;
        w_memtoreg = 1'b0;
        w_branch   = 1'b0;
        w_jump     = 1'b0;
        w_alu_ctrl = ALU_ADD;
        case (w_op)
            OP_RTYPE: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                case (w_fn)
                    FN_ADD:  w_alu_ctrl = ALU_ADD;
                    FN_SUB:  w_alu_ctrl = ALU_SUB;
                    FN_AND:  w_alu_ctrl = ALU_AND;
                    FN_OR:   w_alu_ctrl = ALU_OR;
                    FN_SLT:  w_alu_ctrl = ALU_SLT;
                    FN_SLL:  w_alu_ctrl = ALU_SLL;
                    FN_SRL:  w_alu_ctrl = ALU_SRL;
                    FN_SRA:  w_alu_ctrl = ALU_SRA;
                    default: w_regwrite = 1'b0;
                endcase
            end
            OP_ADDI: begin
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            OP_LW: begin
                w_alusrc   = 1'b1;
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            OP_SW:   w_alusrc = 1'b1;
            OP_BEQ: begin
                w_branch   = 1'b1;
                w_alu_ctrl = ALU_SUB;
            end
            OP_J:    w_jump = 1'b1;
            default: ;
        endcase
    end

    assign w_rs_val = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? '0 : r_rf[w_rt];
    assign w_alu_b  = w_alusrc ? w_simm : w_rt_val;

    sra_0_alu u_alu (
        .a       (w_rs_val),
        .b       (w_alu_b),
        .shamt   (w_instr[10:6]),
        .control (w_alu_ctrl),
        .result  (w_alu_res),
        .zero    (w_zero)
    );

    assign dataadr   = w_alu_res;
    assign writedata = w_rt_val;
    assign memwrite  = (w_op == OP_SW) && reset;

    assign w_rdata = r_dmem[dataadr[DAW+1:2]];
    assign w_wdata = w_memtoreg ? w_rdata : w_alu_res;
    assign w_waddr = w_regdst ? w_rd : w_rt;

    assign w_pc4 = r_pc + 32'd4;
    always_comb begin
        w_pc_next = w_pc4;
        if (w_jump)
            w_pc_next = {w_pc4[31:28], w_instr[25:0], 2'b00};
        else if (w_branch && w_zero)
            w_pc_next = w_pc4 + {w_simm[29:0], 2'b00};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_pc <= '0;
        else
            r_pc <= w_pc_next;
    end

    // Storage is never cleared; writes are gated by reset instead.
    always_ff @(posedge clk) begin
        if (w_regwrite && reset && (w_waddr != 5'd0))
            r_rf[w_waddr] <= w_wdata;
        if (memwrite)
            r_dmem[dataadr[DAW+1:2]] <= writedata;
    end

endmodule

// File: tb/tb_sra_0.sv
// Directed bench for sra_0: boot-program timeline, injected sra/srl/branch/jump instructions, mid-run reset.
module tb_sra_0;

    logic        clk;
    logic        reset;
    logic [31:0] writedata;
    logic [31:0] dataadr;
    logic        memwrite;

    int unsigned total;
    int unsigned bad;

    sra_0 #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .writedata (writedata),
        .dataadr   (dataadr),
        .memwrite  (memwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;

        // Reset held low for 22 ns.
        @(negedge clk);
        chk("rst_pc_a", dut.r_pc, 32'h0);
        chk("rst_mw_a", {31'b0, memwrite}, 32'h0);
        @(negedge clk);
        chk("rst_pc_b", dut.r_pc, 32'h0);
        chk("rst_mw_b", {31'b0, memwrite}, 32'h0);
        #2 reset = 1'b1;

        // Boot program timeline.
        @(negedge clk);
        chk("boot_r2", dut.r_rf[2], 32'hFFFFFFFE);
        chk("boot_mw1", {31'b0, memwrite}, 32'h0);
        @(negedge clk);
        chk("boot_r4", dut.r_rf[4], 32'hFFFFFFFF);
        chk("boot_mw3", {31'b0, memwrite}, 32'h1);
        chk("boot_adr", dataadr, 32'h8);
        chk("boot_wd", writedata, 32'hFFFFFFFF);
        @(negedge clk);
        chk("boot_mw4", {31'b0, memwrite}, 32'h0);
        chk("boot_mem8", dut.r_dmem[2], 32'hFFFFFFFF);
        chk("boot_pc", dut.r_pc, 32'hC);
        @(negedge clk);
        chk("boot_mw5", {31'b0, memwrite}, 32'h0);

        // Injected instructions.
        force dut.w_instr = 32'h08000010;             // j 0x40
        #1 chk("j_mw", {31'b0, memwrite}, 32'h0);
        @(negedge clk);
        chk("j_pc", dut.r_pc, 32'h40);
        force dut.w_instr = 32'h10000003;             // beq $0,$0,+3
        @(negedge clk);
        chk("beq_pc", dut.r_pc, 32'h50);
        force dut.w_instr = 32'h20020001;             // addi $2,$0,1
        @(negedge clk);
        chk("addi_r2", dut.r_rf[2], 32'h1);
        force dut.w_instr = 32'h000217C0;             // sll $2,$2,31
        @(negedge clk);
        chk("sll_r2", dut.r_rf[2], 32'h80000000);
        force dut.w_instr = 32'h00022FC3;             // sra $5,$2,31
        @(negedge clk);
        chk("sra31_r5", dut.r_rf[5], 32'hFFFFFFFF);
        force dut.w_instr = 32'h2043FFF0;             // addi $3,$2,-16
        @(negedge clk);
        chk("addi_r3", dut.r_rf[3], 32'h7FFFFFF0);
        force dut.w_instr = 32'h00033103;             // sra $6,$3,4
        @(negedge clk);
        chk("sra4_r6", dut.r_rf[6], 32'h07FFFFFF);
        force dut.w_instr = 32'h2007FFFE;             // addi $7,$0,-2
        @(negedge clk);
        chk("addi_r7", dut.r_rf[7], 32'hFFFFFFFE);
        force dut.w_instr = 32'h00074083;             // sra $8,$7,2
        @(negedge clk);
        chk("sra2_r8", dut.r_rf[8], 32'hFFFFFFFF);
        force dut.w_instr = 32'h00074882;             // srl $9,$7,2
        @(negedge clk);
        chk("srl2_r9", dut.r_rf[9], 32'h3FFFFFFF);
        force dut.w_instr = 32'h00075003;             // sra $10,$7,0
        @(negedge clk);
        chk("sra0_r10", dut.r_rf[10], 32'hFFFFFFFE);
        force dut.w_instr = 32'h00070083;             // sra $0,$7,2
        @(negedge clk);
        force dut.w_instr = 32'hAC000008;             // sw $0,8($0)
        #1;
        chk("z0_mw", {31'b0, memwrite}, 32'h1);
        chk("z0_adr", dataadr, 32'h8);
        chk("z0_wd", writedata, 32'h0);
        @(negedge clk);
        chk("z0_mem8", dut.r_dmem[2], 32'h0);
        force dut.w_instr = 32'hFC000000;             // undefined opcode
        #1 chk("nop_mw", {31'b0, memwrite}, 32'h0);
        @(negedge clk);
        chk("nop_pc", dut.r_pc, 32'h80);
        release dut.w_instr;

        // Reset gating: addi at pc 0 must not write while reset is low.
        reset = 1'b0;
        #1;
        chk("rst2_pc", dut.r_pc, 32'h0);
        chk("rst2_mw", {31'b0, memwrite}, 32'h0);
        @(negedge clk);
        chk("rst2_r2", dut.r_rf[2], 32'h80000000);
        chk("rst2_mem8", dut.r_dmem[2], 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rerun_r2", dut.r_rf[2], 32'hFFFFFFFE);
        chk("rerun_pc", dut.r_pc, 32'h4);
        // Reset during the 2nd instruction.
        reset = 1'b0;
        #1;
        chk("mid_pc", dut.r_pc, 32'h0);
        chk("mid_mw", {31'b0, memwrite}, 32'h0);
        @(negedge clk);
        chk("mid_pc_hold", dut.r_pc, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_mw1", {31'b0, memwrite}, 32'h0);
        @(negedge clk);
        chk("mid_mw3", {31'b0, memwrite}, 32'h1);
        chk("mid_adr", dataadr, 32'h8);
        chk("mid_wd", writedata, 32'hFFFFFFFF);
        @(negedge clk);
        chk("mid_mem8", dut.r_dmem[2], 32'hFFFFFFFF);
        chk("mid_mw4", {31'b0, memwrite}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
